score_keeper: RTL and testbench

- Turn-based score engine for the two-player card-matching game.
- Consumes one "pair attempt" event per turn from the board/compare logic.
- Computes each player's next score with a saturating ripple adder and holds both scores in its own registers.
- Owns current-player, streak, pairs-remaining and game-over/winner status; its outputs drive the score display and end-of-game logic.

---
 rtl/score_pkg.sv | 28 ++
 rtl/score_adder.sv | 24 ++
 rtl/score_keeper.sv | 174 +++++++++++++++++
 tb/tb_score_keeper.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and defaults for the card-matching score engine.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_UPDATE = 2'b10,
    ST_OVER   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  localparam int DEF_SCORE_W      = 8;
  localparam int DEF_TOTAL_PAIRS  = 8;
  localparam int DEF_MATCH_POINTS = 2;
  localparam int DEF_STREAK_BONUS = 1;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
    full_adder = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/score_adder.sv
// Saturating ripple-carry adder used to add points to the active player's score.
module score_adder
  import score_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] incr,
  output logic [SCORE_W-1:0] sum
);

  logic [SCORE_W:0]   carry_s;
  logic [SCORE_W-1:0] raw_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < SCORE_W; i++) begin : g_bit
    assign {carry_s[i+1], raw_s[i]} = full_adder(score[i], incr[i], carry_s[i]);
  end

  // A carry out of the top bit means overflow: clamp to the largest score.
  assign sum = carry_s[SCORE_W] ? {SCORE_W{1'b1}} : raw_s;

endmodule

// File: rtl/score_keeper.sv
// Turn-based score engine: accepts one pair-attempt per turn, keeps both
// scores, turn owner, streak, pairs remaining and end-of-game status.
module score_keeper
  import score_pkg::*;
#(
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int MATCH_POINTS = DEF_MATCH_POINTS,
  parameter int STREAK_BONUS = DEF_STREAK_BONUS,
  parameter int TOTAL_PAIRS  = DEF_TOTAL_PAIRS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic               evt_match,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               cur_player,
  output logic [7:0]         pairs_left,
  output logic               upd_valid,
  output logic               game_over,
  output logic [1:0]         winner
);

  state_e             state_r, state_nxt_s;
  logic [SCORE_W-1:0] score_p1_r, score_p2_r, p1_nxt_s, p2_nxt_s;
  logic               cur_player_r, cur_nxt_s;
  logic               streak_r, streak_nxt_s;
  logic [7:0]         pairs_r, pairs_nxt_s;
  logic               match_r, match_nxt_s;
  logic               upd_valid_r, upd_nxt_s;
  logic               ready_r, ready_nxt_s;
  logic               over_r, over_nxt_s;
  winner_e            winner_r, winner_nxt_s;
  logic [SCORE_W-1:0] operand_s, incr_s, sum_s;

  // Select the active player's score and the points this match is worth.
  always_comb begin
    operand_s = score_p1_r;
    incr_s    = SCORE_W'(MATCH_POINTS);
    if (cur_player_r) begin
      operand_s = score_p2_r;
    end else begin
      operand_s = score_p1_r;
    end
    if (streak_r) begin
      incr_s = SCORE_W'(MATCH_POINTS + STREAK_BONUS);
    end else begin
      incr_s = SCORE_W'(MATCH_POINTS);
    end
  end

  score_adder #(.SCORE_W(SCORE_W)) u_adder (
    .score (operand_s),
    .incr  (incr_s),
    .sum   (sum_s)
  );

  // Next-state and next-output logic; start overrides everything, including a pending update.
  always_comb begin
    state_nxt_s  = state_r;
    p1_nxt_s     = score_p1_r;
    p2_nxt_s     = score_p2_r;
    cur_nxt_s    = cur_player_r;
    streak_nxt_s = streak_r;
    pairs_nxt_s  = pairs_r;
    match_nxt_s  = match_r;
    upd_nxt_s    = 1'b0;
    winner_nxt_s = WIN_NONE;
    if (start) begin
      state_nxt_s  = ST_PLAY;
      p1_nxt_s     = {SCORE_W{1'b0}};
      p2_nxt_s     = {SCORE_W{1'b0}};
      cur_nxt_s    = 1'b0;
      streak_nxt_s = 1'b0;
      pairs_nxt_s  = 8'(TOTAL_PAIRS);
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_PLAY: begin
          if (evt_valid) begin
            match_nxt_s = evt_match;
            state_nxt_s = ST_UPDATE;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
        ST_UPDATE: begin
          upd_nxt_s = 1'b1;
          if (match_r) begin
            if (cur_player_r) begin
              p2_nxt_s = sum_s;
            end else begin
              p1_nxt_s = sum_s;
            end
            streak_nxt_s = 1'b1;
            if (pairs_r > 8'd1) begin
              pairs_nxt_s = pairs_r - 8'd1;
              state_nxt_s = ST_PLAY;
            end else begin
              pairs_nxt_s = 8'd0;
              state_nxt_s = ST_OVER;
            end
          end else begin
            streak_nxt_s = 1'b0;
            cur_nxt_s    = ~cur_player_r;
            state_nxt_s  = ST_PLAY;
          end
        end
        ST_OVER: begin
          state_nxt_s = ST_OVER;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    ready_nxt_s = (state_nxt_s == ST_PLAY);
    over_nxt_s  = (state_nxt_s == ST_OVER);
    if (over_nxt_s) begin
      if (p1_nxt_s > p2_nxt_s) begin
        winner_nxt_s = WIN_P1;
      end else if (p2_nxt_s > p1_nxt_s) begin
        winner_nxt_s = WIN_P2;
      end else begin
        winner_nxt_s = WIN_TIE;
      end
    end else begin
      winner_nxt_s = WIN_NONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      score_p1_r   <= {SCORE_W{1'b0}};
      score_p2_r   <= {SCORE_W{1'b0}};
      cur_player_r <= 1'b0;
      streak_r     <= 1'b0;
      pairs_r      <= 8'd0;
      match_r      <= 1'b0;
      upd_valid_r  <= 1'b0;
      ready_r      <= 1'b0;
      over_r       <= 1'b0;
      winner_r     <= WIN_NONE;
    end else begin
      state_r      <= state_nxt_s;
      score_p1_r   <= p1_nxt_s;
      score_p2_r   <= p2_nxt_s;
      cur_player_r <= cur_nxt_s;
      streak_r     <= streak_nxt_s;
      pairs_r      <= pairs_nxt_s;
      match_r      <= match_nxt_s;
      upd_valid_r  <= upd_nxt_s;
      ready_r      <= ready_nxt_s;
      over_r       <= over_nxt_s;
      winner_r     <= winner_nxt_s;
    end
  end

  assign evt_ready  = ready_r;
  assign score_p1   = score_p1_r;
  assign score_p2   = score_p2_r;
  assign cur_player = cur_player_r;
  assign pairs_left = pairs_r;
  assign upd_valid  = upd_valid_r;
  assign game_over  = over_r;
  assign winner     = winner_r;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (8-bit and 4-bit scores) share stimulus
// and are checked every cycle against a game-rule model.
module tb_score_keeper;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic evt_valid = 1'b0;
  logic evt_match = 1'b0;

  logic       ready_a, ready_b, cur_a, cur_b, upd_a, upd_b, over_a, over_b;
  logic [7:0] p1_a, p2_a, pairs_a, pairs_b;
  logic [3:0] p1_b, p2_b;
  logic [1:0] win_a, win_b;

  score_keeper #(.SCORE_W(8)) dut_a (
    .clock(clock), .reset(reset), .start(start), .evt_valid(evt_valid),
    .evt_ready(ready_a), .evt_match(evt_match), .score_p1(p1_a), .score_p2(p2_a),
    .cur_player(cur_a), .pairs_left(pairs_a), .upd_valid(upd_a),
    .game_over(over_a), .winner(win_a)
  );

  score_keeper #(.SCORE_W(4)) dut_b (
    .clock(clock), .reset(reset), .start(start), .evt_valid(evt_valid),
    .evt_ready(ready_b), .evt_match(evt_match), .score_p1(p1_b), .score_p2(p2_b),
    .cur_player(cur_b), .pairs_left(pairs_b), .upd_valid(upd_b),
    .game_over(over_b), .winner(win_b)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int upd_count = 0;

  // Game-rule model: index 0 = 8-bit instance, 1 = 4-bit instance.
  int m_s[2][2];
  int max_s[2] = '{255, 15};
  int m_cur, m_streak, m_pairs;
  bit m_accept, m_pend, m_pend_match, m_upd, m_over;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_winner(input int k);
    if (!m_over) return 0;
    if (m_s[k][0] > m_s[k][1]) return 1;
    if (m_s[k][1] > m_s[k][0]) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s[k][0] = 0;
      m_s[k][1] = 0;
    end
    m_cur = 0; m_streak = 0; m_pairs = 0;
    m_accept = 0; m_pend = 0; m_pend_match = 0; m_upd = 0; m_over = 0;
  endtask

  task automatic model_step();
    int pts;
    m_upd = 0;
    if (start) begin
      for (int k = 0; k < 2; k++) begin
        m_s[k][0] = 0;
        m_s[k][1] = 0;
      end
      m_cur = 0; m_streak = 0; m_pairs = 8;
      m_pend = 0; m_accept = 1; m_over = 0;
    end else if (m_pend) begin
      m_pend = 0;
      m_upd  = 1;
      if (m_pend_match) begin
        pts = 2 + (m_streak != 0 ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
          m_s[k][m_cur] = m_s[k][m_cur] + pts;
          if (m_s[k][m_cur] > max_s[k]) m_s[k][m_cur] = max_s[k];
        end
        m_streak = 1;
        m_pairs  = m_pairs - 1;
        if (m_pairs == 0) begin
          m_over = 1; m_accept = 0;
        end else begin
          m_accept = 1;
        end
      end else begin
        m_streak = 0;
        m_cur    = 1 - m_cur;
        m_accept = 1;
      end
    end else if (m_accept && evt_valid) begin
      m_pend = 1;
      m_pend_match = evt_match;
      m_accept = 0;
    end
  endtask

  // Model advances on each clock edge, and resets immediately on reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clock);
      check("a.score_p1", p1_a, m_s[0][0]);
      check("a.score_p2", p2_a, m_s[0][1]);
      check("b.score_p1", p1_b, m_s[1][0]);
      check("b.score_p2", p2_b, m_s[1][1]);
      check("a.winner", win_a, exp_winner(0));
      check("b.winner", win_b, exp_winner(1));
      check("cur_player", cur_a, m_cur);
      check("pairs_left", pairs_a, m_pairs);
      check("upd_valid", upd_a, m_upd);
      check("game_over", over_a, m_over);
      check("evt_ready", ready_a, m_accept);
      check("b.evt_ready", ready_b, ready_a);
      if (upd_a) upd_count++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Offer one event once the block is ready; called and returns on a falling edge.
  task automatic do_event(input bit m);
    int w;
    w = 0;
    while (!ready_a && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("ready_seen", ready_a, 1);
    evt_valid = 1'b1;
    evt_match = m;
    @(negedge clock);
    evt_valid = 1'b0;
  endtask

  initial begin
    int u0;
    idle(2);
    check("rst.score_p1", p1_a, 0);
    check("rst.pairs", pairs_a, 0);
    check("rst.ready", ready_a, 0);
    check("rst.winner", win_a, 0);
    reset = 1'b0;
    idle(1);

    // New game, then match, match, mismatch, match.
    pulse_start();
    check("start.pairs", pairs_a, 8);
    check("start.ready", ready_a, 1);
    do_event(1'b1);
    do_event(1'b1);
    do_event(1'b0);
    do_event(1'b1);
    idle(2);
    check("seq.p1", p1_a, 5);
    check("seq.p2", p2_a, 2);
    check("seq.pairs", pairs_a, 5);
    check("seq.cur", cur_a, 1);
    check("seq.upd_pulses", upd_count, 4);

    // Run of eight matches by P1: saturation in the 4-bit instance, then game over.
    pulse_start();
    repeat (5) do_event(1'b1);
    idle(2);
    check("sat.b_p1_14", p1_b, 14);
    do_event(1'b1);
    idle(2);
    check("sat.b_p1_15", p1_b, 15);
    check("sat.b_p2", p2_b, 0);
    check("sat.a_p1", p1_a, 17);
    do_event(1'b1);
    do_event(1'b1);
    idle(2);
    check("over.flag", over_a, 1);
    check("over.winner", win_a, 1);
    check("over.ready", ready_a, 0);
    check("over.a_p1", p1_a, 23);
    u0 = upd_count;
    evt_valid = 1'b1;
    evt_match = 1'b1;
    idle(5);
    evt_valid = 1'b0;
    idle(1);
    check("over.ignored_p1", p1_a, 23);
    check("over.ignored_upd", upd_count, u0);

    // start during the UPDATE cycle discards the pending event.
    pulse_start();
    u0 = upd_count;
    do_event(1'b1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    idle(2);
    check("abort.p1", p1_a, 0);
    check("abort.upd", upd_count, u0);
    check("abort.ready", ready_a, 1);

    // Asynchronous reset between edges while in UPDATE.
    do_event(1'b1);
    do_event(1'b1);
    #2 reset = 1'b1;
    #1;
    check("areset.p1", p1_a, 0);
    check("areset.pairs", pairs_a, 0);
    check("areset.ready", ready_a, 0);
    check("areset.upd", upd_a, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    check("areset.idle_ready", ready_a, 0);

    // Randomized play with occasional restarts.
    pulse_start();
    for (int c = 0; c < 2500; c++) begin
      start     = ($urandom_range(0, 59) == 0);
      evt_valid = $urandom_range(0, 1);
      evt_match = ($urandom_range(0, 2) != 0);
      @(negedge clock);
    end
    start = 1'b0;
    evt_valid = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
